prbs_checker: RTL

Receive-side checker for the LFSR pseudo-random bit stream produced by the PRBS generator. It samples one bit per `bit_valid` strobe and self-synchronises its local LFSR to the incoming stream. Once locked, it flags every bit that differs from the predicted sequence and keeps a saturating error count. It closes the loop on the board, so a generator→checker path can be verified at the slow LED rate or at full clock rate.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs_checker_if.sv | 22 ++
 rtl/prbs_checker_sat_counter.sv | 23 ++
 rtl/prbs_checker.sv | 112 +++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: sequence states and the default polynomial used by both generator and checker.
// Pure declarations, no timing or flow control.
package prbs_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } prbs_state_t;

   localparam int PRBS_N     = 7;
   localparam int PRBS_TAP_A = 7;
   localparam int PRBS_TAP_B = 6;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Receive-bit strobe, count clear and checker status bundle.
// Strobe only, no ready: the checker accepts one bit per clock.
interface prbs_checker_if #(
   parameter int CNT_W = 16
);
   logic             bit_valid;
   logic             bit_in;
   logic             clear_counts;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;

   modport master (
      output bit_valid, bit_in, clear_counts,
      input  locked, err_pulse, err_count
   );

   modport slave (
      input  bit_valid, bit_in, clear_counts,
      output locked, err_pulse, err_count
   );
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency 1, never stalls.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for lock, then free-runs its LFSR and counts mismatches.
// Latency 1 from strobe to outputs; no backpressure, one bit per clock sustained.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int N           = PRBS_N,
   parameter int TAP_A       = PRBS_TAP_A,
   parameter int TAP_B       = PRBS_TAP_B,
   parameter int SYNC_COUNT  = 16,
   parameter int WINDOW      = 128,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_W       = 16
) (
   input  logic           clk_in,
   input  logic           rst,
   prbs_checker_if.slave  bus
);

   localparam int FILL_W  = cnt_width(N);
   localparam int MATCH_W = cnt_width(SYNC_COUNT);
   localparam int WBITS_W = cnt_width(WINDOW - 1);
   localparam int WERR_W  = cnt_width(LOSS_THRESH);

   prbs_state_t        state;
   logic [N-1:0]       hist;
   logic [FILL_W-1:0]  fill_cnt;
   logic [MATCH_W-1:0] match_cnt;
   logic [WBITS_W-1:0] win_bits;
   logic [WERR_W-1:0]  win_err;
   logic [WERR_W-1:0]  win_err_nxt;
   logic               locked_q;
   logic               err_pulse_q;
   logic               predict;
   logic               mismatch;
   logic               err_inc;

   assign predict     = hist[TAP_A-1] ^ hist[TAP_B-1];
   assign mismatch    = bus.bit_in ^ predict;
   assign err_inc     = bus.bit_valid && (state == LOCKED) && mismatch;
   // win_err stays below LOSS_THRESH, so one more error always fits.
   assign win_err_nxt = win_err + WERR_W'(mismatch);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state       <= HUNT;
         hist        <= '0;
         fill_cnt    <= '0;
         match_cnt   <= '0;
         win_bits    <= '0;
         win_err     <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         err_pulse_q <= err_inc;
         if (bus.bit_valid) begin
            case (state)
               HUNT: begin
                  hist <= {hist[N-2:0], bus.bit_in};
                  if (fill_cnt != FILL_W'(N)) begin
                     fill_cnt <= fill_cnt + FILL_W'(1);
                  end else if (!mismatch && (hist != '0)) begin
                     if (match_cnt == MATCH_W'(SYNC_COUNT - 1)) begin
                        state     <= LOCKED;
                        locked_q  <= 1'b1;
                        match_cnt <= '0;
                        win_bits  <= '0;
                        win_err   <= '0;
                     end else begin
                        match_cnt <= match_cnt + MATCH_W'(1);
                     end
                  end else begin
                     // A dead all-zero line predicts zeros forever, so it must never count.
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  hist <= {hist[N-2:0], predict};
                  if (win_err_nxt == WERR_W'(LOSS_THRESH)) begin
                     state     <= HUNT;
                     locked_q  <= 1'b0;
                     match_cnt <= '0;
                     fill_cnt  <= '0;
                     win_bits  <= '0;
                     win_err   <= '0;
                  end else if (win_bits == WBITS_W'(WINDOW - 1)) begin
                     win_bits <= '0;
                     win_err  <= '0;
                  end else begin
                     win_bits <= win_bits + WBITS_W'(1);
                     win_err  <= win_err_nxt;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk_in (clk_in),
      .rst    (rst),
      .inc    (err_inc),
      .clr    (bus.clear_counts),
      .count  (bus.err_count)
   );

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;

endmodule
